uart_tx: RTL

UART transmitter that serialises bytes onto the `tx` line, as the counterpart to the `uart` receiver. Frame format: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 2 stop bits. The default rate is 9600 baud from the 50 MHz board clock. A one-entry holding register lets the next byte be queued while a frame is in flight, so frames can be sent back to back with no idle gap.

---
 rtl/uart_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits.
// A one-entry holding register lets the next byte queue up while a frame is on
// the line, so consecutive frames leave with no idle gap between them.
module uart_tx #(
   parameter int INPUT_CLOCK         = 50000000,
   parameter int UART_BAUD           = 9600,
   parameter int CLOCKS_BETWEEN_BITS = INPUT_CLOCK / UART_BAUD
) (
   input  logic       clk50MHz,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   // A bit period of one clock would give a zero-width counter; keep at least one bit.
   localparam int CNT_W = (CLOCKS_BETWEEN_BITS > 1) ? $clog2(CLOCKS_BETWEEN_BITS) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_BETWEEN_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic [7:0]       hold_data_q, hold_data_d;
   logic             hold_valid_q, hold_valid_d;
   logic             tx_q, tx_d;

   logic             baud_tc;
   logic             accept;
   logic             load;

   assign baud_tc = (baud_cnt_q == BAUD_LAST);
   assign accept  = tx_valid && !hold_valid_q;

   // Next state and shifter: load from the holding register when idle or at the end of STOP2.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      load      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (hold_valid_q) load = 1'b1;
         end
         S_START: begin
            if (baud_tc) state_d = S_DATA;
         end
         S_DATA: begin
            if (baud_tc) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (baud_tc) state_d = S_STOP1;
         end
         S_STOP1: begin
            if (baud_tc) state_d = S_STOP2;
         end
         S_STOP2: begin
            if (baud_tc) begin
               if (hold_valid_q) load    = 1'b1;
               else              state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
         state_d   = S_START;
         shift_d   = hold_data_q;
         parity_d  = ^hold_data_q;
         bit_cnt_d = 3'd0;
      end
   end

   // Baud counter restarts on every state change and stays parked at zero while idle.
   always_comb begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
      if (baud_tc || (state_d != state_q) || (state_q == S_IDLE)) baud_cnt_d = '0;
   end

   // Holding register: filled on accept, emptied when the shifter takes the byte.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      if (load) hold_valid_d = 1'b0;
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = tx_data;
      end
   end

   // Line level follows the state being entered so tx can come straight from a flop.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
   end

   // State register; reset drops any pending or in-flight byte.
   always_ff @(posedge clk50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         baud_cnt_q   <= '0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         parity_q     <= 1'b0;
         hold_data_q  <= 8'd0;
         hold_valid_q <= 1'b0;
         tx_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         tx_q         <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = !hold_valid_q;
   assign busy     = (state_q != S_IDLE) || hold_valid_q;

endmodule
